mmio_store_unit: RTL

//  Write side of the CPU memory-mapped I/O window. It decodes CPU stores to MMIO offsets and

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/mmio_store_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// MMIO window offsets shared by the store and read sides, plus the store-kind decode.
package mmio_pkg;

  localparam logic [7:0] OFF_TX_DATA  = 8'h08;
  localparam logic [7:0] OFF_CNT_CLR  = 8'h18;
  localparam logic [7:0] OFF_STAT_CLR = 8'h1C;
  localparam logic [7:0] OFF_LED      = 8'h30;

  typedef enum logic [2:0] {
    ST_NONE,
    ST_TX,
    ST_CNT_CLR,
    ST_STAT_CLR,
    ST_LED
  } store_kind_e;

  // Word-aligned decode; the two byte-lane bits of the offset are ignored.
  function automatic store_kind_e decode_store(input logic [7:0] addr);
    logic [7:0] off;
    off = {addr[7:2], 2'b00};
    case (off)
      OFF_TX_DATA:  decode_store = ST_TX;
      OFF_CNT_CLR:  decode_store = ST_CNT_CLR;
      OFF_STAT_CLR: decode_store = ST_STAT_CLR;
      OFF_LED:      decode_store = ST_LED;
      default:      decode_store = ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_store_unit.sv
// Write side of the MMIO window: store decode, UART TX byte queue, overflow flag,
// LED register and counter-clear pulse.
module mmio_store_unit
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_en,
  input  logic [7:0]       st_addr,
  input  logic [31:0]      st_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_ready_status,
  output logic             tx_overflow,
  output logic             counters_clr,
  output logic [LED_W-1:0] led
);

  localparam int AW = $clog2(FIFO_DEPTH);

  store_kind_e      kind;
  logic             fifo_full, fifo_empty, pop, push, drop;
  logic [AW:0]      fifo_count;
  logic             ovf_q, ovf_d;
  logic             clr_q, clr_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             unused_bits;

  assign kind = st_en ? decode_store(st_addr) : ST_NONE;
  assign pop  = tx_valid && tx_ready;
  assign push = (kind == ST_TX);
  assign drop = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (st_data[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid        = !fifo_empty;
  assign tx_ready_status = (fifo_count < (AW+1)'(FIFO_DEPTH));

  always_comb begin
    ovf_d = ovf_q;
    clr_d = (kind == ST_CNT_CLR);
    led_d = led_q;
    if (kind == ST_STAT_CLR) ovf_d = 1'b0;
    // A dropped push sets the flag even against a clear in the same cycle.
    if (drop)                ovf_d = 1'b1;
    if (kind == ST_LED)      led_d = st_data[LED_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      clr_q <= 1'b0;
      led_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      clr_q <= clr_d;
      led_q <= led_d;
    end
  end

  assign tx_overflow  = ovf_q;
  assign counters_clr = clr_q;
  assign led          = led_q;

  assign unused_bits = ^{st_data[31:8]};

endmodule
